// File: rtl/sorter_pkg.sv
// rtl/sorter_pkg.sv - shared constants and state type for the sort frame sequencer
package sorter_pkg;

    localparam int DATA_NUM_C = 256;
    localparam int KEY_NUM_C  = 256;
    localparam int DATA_W     = 8;
    localparam int CNT_W      = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/sort_frame_buffer.sv
// rtl/sort_frame_buffer.sv - frame store, one write port and one registered read port
module sort_frame_buffer
    import sorter_pkg::*;
#(
    parameter int DEPTH = DATA_NUM_C,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Only the read register is reset so the sorter sees zero data out of reset.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            rd_data_o <= '0;
        end else begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/sort_frame_sequencer.sv
// rtl/sort_frame_sequencer.sv - loads one frame, replays it KEY_NUM times into the sorter
module sort_frame_sequencer
    import sorter_pkg::*;
#(
    parameter int DATA_NUM = DATA_NUM_C,
    parameter int KEY_NUM  = KEY_NUM_C
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] srt_data,
    output logic              srt_valid,
    input  logic              srt_vout,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  res_cnt
);

    localparam int AW = $clog2(DATA_NUM);
    localparam int PW = $clog2(KEY_NUM);
    localparam logic [AW-1:0]    LAST_IDX  = AW'(DATA_NUM - 1);
    localparam logic [PW-1:0]    LAST_PASS = PW'(KEY_NUM - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DATA_NUM);

    seq_state_t       state_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [PW-1:0]    pass_q;
    logic             drain_q;
    logic             in_ready_q;
    logic             srt_valid_q;
    logic             vld_d1_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [CNT_W-1:0] res_cnt_q;
    logic [CNT_W-1:0] res_cnt_d;
    logic             hs;
    logic             first_hs;
    logic [AW-1:0]    wr_addr;

    assign hs       = in_valid & in_ready_q;
    assign first_hs = hs & (state_q == ST_IDLE);
    assign wr_addr  = (state_q == ST_LOAD) ? wr_ptr_q : '0;

    sort_frame_buffer #(
        .DEPTH (DATA_NUM),
        .AW    (AW)
    ) u_buf (
        .clk       (clk),
        .xrst      (xrst),
        .wr_en_i   (hs),
        .wr_addr_i (wr_addr),
        .wr_data_i (in_data),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (srt_data)
    );

    // valid_out is stale while valid_in is low, so only count beats backed by a real input beat.
    always_comb begin
        res_cnt_d = res_cnt_q;
        if (first_hs) begin
            res_cnt_d = '0;
        end else if (busy_q && vld_d1_q && srt_vout && (res_cnt_q != '1)) begin
            res_cnt_d = res_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pass_q      <= '0;
            drain_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            srt_valid_q <= 1'b0;
            vld_d1_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            res_cnt_q   <= '0;
        end else begin
            srt_valid_q <= (state_q == ST_SCAN);
            vld_d1_q    <= srt_valid_q;
            res_cnt_q   <= res_cnt_d;
            unique case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (hs) begin
                        state_q  <= ST_LOAD;
                        wr_ptr_q <= AW'(1);
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
                        if (wr_ptr_q == LAST_IDX) begin
                            state_q    <= ST_SCAN;
                            in_ready_q <= 1'b0;
                            wr_ptr_q   <= '0;
                            rd_ptr_q   <= '0;
                            pass_q     <= '0;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (rd_ptr_q == LAST_IDX) begin
                        rd_ptr_q <= '0;
                        if (pass_q == LAST_PASS) begin
                            state_q <= ST_DRAIN;
                            drain_q <= 1'b0;
                            pass_q  <= '0;
                        end else begin
                            pass_q <= pass_q + 1'b1;
                        end
                    end else begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        err_q   <= (res_cnt_d != FULL_CNT);
                    end
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign srt_valid = srt_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign res_cnt   = res_cnt_q;

endmodule

// File: tb/tb_sort_frame_sequencer.sv
// tb/tb_sort_frame_sequencer.sv - scoreboard bench with a behavioural counting sorter
module tb_sort_frame_sequencer;
    import sorter_pkg::*;

    localparam int DN = 32;
    localparam int KN = 16;
    localparam int NB = DN * KN;

    logic       clk = 1'b0;
    logic       xrst = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] srt_data;
    logic       srt_valid;
    logic       busy;
    logic       done;
    logic       err;
    logic [8:0] res_cnt;

    logic       s_vout;
    logic [7:0] s_dout;
    int         s_j;
    int         s_k;
    logic       tb_vld_d1;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_hs = 0;
    int beat_cnt = 0;
    int done_cnt = 0;
    int nd = 0;
    bit bad_scan = 0;
    bit done_prev = 0;

    logic [7:0] fr [DN];
    logic [7:0] acc [$];
    logic [7:0] exp_q [$];
    int         exp_cnt_q [$];

    sort_frame_sequencer #(
        .DATA_NUM (DN),
        .KEY_NUM  (KN)
    ) dut (
        .clk       (clk),
        .xrst      (xrst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .srt_data  (srt_data),
        .srt_valid (srt_valid),
        .srt_vout  (s_vout),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .res_cnt   (res_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream counting sorter: key is its own pass count, output held when no input beat.
    always @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            s_vout    <= 1'b0;
            s_dout    <= '0;
            s_j       <= 0;
            s_k       <= 0;
            tb_vld_d1 <= 1'b0;
        end else begin
            tb_vld_d1 <= srt_valid;
            if (srt_valid) begin
                s_vout <= (int'(srt_data) == s_k);
                s_dout <= srt_data;
                if (s_j == DN - 1) begin
                    s_j <= 0;
                    s_k <= (s_k == KN - 1) ? 0 : s_k + 1;
                end else begin
                    s_j <= s_j + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        int n;
        if (!xrst) begin
            acc.delete();
            exp_q.delete();
            exp_cnt_q.delete();
            beat_cnt  = 0;
            bad_scan  = 0;
            done_prev = 0;
        end else begin
            if (in_valid && in_ready) begin
                acc.push_back(in_data);
                last_hs = cyc;
                if (acc.size() == DN) begin
                    n = 0;
                    for (int k = 0; k < KN; k++) begin
                        for (int i = 0; i < DN; i++) begin
                            if (int'(acc[i]) == k) begin
                                exp_q.push_back(acc[i]);
                                n++;
                            end
                        end
                    end
                    exp_cnt_q.push_back(n);
                    acc.delete();
                end
            end
            if (srt_valid) begin
                if (beat_cnt == 0) check("scan_start", cyc - last_hs, 2);
                beat_cnt++;
                if (in_ready || !busy) bad_scan = 1;
            end
            if (tb_vld_d1 && s_vout) begin
                if (exp_q.size() == 0) check("unexpected_out", 1, 0);
                else check("sorted_out", s_dout, exp_q.pop_front());
            end
            if (done_prev) check("ready_after_done", in_ready, 1);
            if (done) begin
                if (exp_cnt_q.size() > 0) n = exp_cnt_q.pop_front();
                else n = -1;
                check("res_cnt", res_cnt, n);
                check("err", err, (n != DN));
                check("beats", beat_cnt, NB);
                check("latency", cyc - last_hs, NB + 3);
                check("ready_low_in_scan", bad_scan, 0);
                check("exp_drained", exp_q.size(), 0);
                beat_cnt = 0;
                bad_scan = 0;
                done_cnt++;
            end
            done_prev = done;
        end
    end

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = '0;
        xrst     = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_srt_valid", srt_valid, 0);
        check("rst_srt_data", srt_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_res_cnt", res_cnt, 0);
        @(posedge clk);
        #1 xrst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input bit gaps, input int budget);
        int  i = 0;
        int  g = 0;
        bit  took;
        while (i < DN && g < budget) begin
            in_data  = fr[i];
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (took) i++;
            g++;
        end
        check("load_count", i, DN);
    endtask

    task automatic wait_done(input int target, input int budget);
        int g = 0;
        while (done_cnt < target && g < budget) begin
            @(posedge clk);
            g++;
        end
        check("done_seen", (done_cnt >= target), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int maxv);
        foreach (fr[i]) fr[i] = 8'($urandom_range(0, maxv));
    endtask

    initial begin
        int g;
        do_reset();

        foreach (fr[i]) fr[i] = 8'h05;
        load_frame(0, 200);
        in_valid = 1'b0;
        nd++;
        wait_done(nd, NB + 100);

        foreach (fr[i]) fr[i] = 8'((DN - 1 - i) / 2);
        load_frame(0, 200);
        in_valid = 1'b0;
        nd++;
        wait_done(nd, NB + 100);

        fill_random(KN - 1);
        load_frame(1, 2000);
        in_valid = 1'b0;
        nd++;
        wait_done(nd, NB + 100);

        fill_random(KN - 1);
        load_frame(0, 200);
        fill_random(KN - 1);
        load_frame(0, NB + 300);
        in_valid = 1'b0;
        nd += 2;
        wait_done(nd, NB + 100);

        fill_random(KN - 1);
        load_frame(0, 200);
        in_valid = 1'b0;
        g = 0;
        while (beat_cnt < DN * 10 && g < NB) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("reached_pass10", (beat_cnt >= DN * 10), 1);
        do_reset();

        fill_random(KN - 1);
        load_frame(1, 2000);
        in_valid = 1'b0;
        nd++;
        wait_done(nd, NB + 100);

        fill_random(2 * KN - 1);
        fr[0] = 8'(KN + 3);
        load_frame(0, 200);
        in_valid = 1'b0;
        nd++;
        wait_done(nd, NB + 100);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("err_sticky", err, 1);
        check("idle_busy", busy, 0);
        @(posedge clk);
        #1;

        fill_random(KN - 1);
        load_frame(1, 2000);
        in_valid = 1'b0;
        nd++;
        wait_done(nd, NB + 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule
